// File: rtl/tl_seq_ctrl_if.sv
// Purpose : bundles the sequencer <-> datapath/control signals of tl_seq_ctrl.
// Latency : n/a (wires only).
// Backpressure : none; all signals are level/pulse, no handshake.
// Ports   : enable, ped_req, int_flags flow into the sequencer (slave inputs);
//           state, cnt_rst, ped_pend, cycle_cnt, fault flow out of it.
interface tl_seq_ctrl_if #(
  parameter int STATE_W = 4
);
  logic               enable;
  logic               ped_req;
  logic [STATE_W-1:0] int_flags;
  logic [STATE_W-1:0] state;
  logic               cnt_rst;
  logic               ped_pend;
  logic [7:0]         cycle_cnt;
  logic               fault;

  modport master (
    output enable, ped_req, int_flags,
    input  state, cnt_rst, ped_pend, cycle_cnt, fault
  );

  modport slave (
    input  enable, ped_req, int_flags,
    output state, cnt_rst, ped_pend, cycle_cnt, fault
  );
endinterface

// File: rtl/tl_seq_ctrl.sv
// Purpose : traffic-light phase sequencer IDLE->INIT->G->Y->R->G.. with
//           pedestrian early-green cut-off, phase watchdog and cycle counter.
// Latency : all outputs registered; a phase change appears one edge after
//           the qualifying input.
// Backpressure : none; int_flags are only honoured outside the blank window.
// Ports   : clk, reset (sync, active-high); bus (tl_seq_ctrl_if.slave):
//           enable/ped_req/int_flags in, state/cnt_rst/ped_pend/cycle_cnt/fault out.
module tl_seq_ctrl #(
  parameter int STATE_W = 4,
  parameter int TMR_W   = 12,
  parameter int MIN_G   = 64,
  parameter int TIMEOUT = 2047,
  parameter int BLANK   = 2
) (
  input  logic         clk,
  input  logic         reset,
  tl_seq_ctrl_if.slave bus
);

  localparam int BLK_W = (BLANK < 1) ? 1 : $clog2(BLANK + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_G, S_Y, S_R, S_FAULT
  } fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               cnt_rst_q, cnt_rst_d;
  logic               ped_pend_q, ped_pend_d;
  logic               fault_q, fault_d;
  logic [7:0]         cyc_q, cyc_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [BLK_W-1:0]   blk_q, blk_d;

  logic in_phase, blank_clr, done, ped_cut, wdog, trans;

  // One-hot datapath encoding; FAULT shows safe red.
  function automatic logic [STATE_W-1:0] phase_bits(input fsm_t f);
    logic [STATE_W-1:0] b;
    b = '0;
    case (f)
      S_INIT:      b[0] = 1'b1;
      S_G:         b[1] = 1'b1;
      S_Y:         b[2] = 1'b1;
      S_R, S_FAULT: b[3] = 1'b1;
      default:     b = '0;
    endcase
    return b;
  endfunction

  always_comb begin
    fsm_d     = fsm_q;
    cyc_d     = cyc_q;
    in_phase  = (fsm_q == S_INIT) || (fsm_q == S_G) || (fsm_q == S_Y) || (fsm_q == S_R);
    blank_clr = (blk_q == '0);
    // state_q already holds the current phase bit, so masking picks only it;
    // in_phase keeps FAULT's red bit from being treated as a live phase.
    done      = in_phase && blank_clr && ((bus.int_flags & state_q) != '0);
    ped_cut   = (fsm_q == S_G) && ped_pend_q && blank_clr && (tmr_q >= TMR_W'(MIN_G));
    wdog      = in_phase && (tmr_q == TMR_W'(TIMEOUT));

    case (fsm_q)
      S_IDLE:  if (bus.enable) fsm_d = S_INIT;
      S_INIT:  if (done) fsm_d = S_G; else if (wdog) fsm_d = S_FAULT;
      S_G:     if (done || ped_cut) fsm_d = S_Y; else if (wdog) fsm_d = S_FAULT;
      S_Y:     if (done) fsm_d = S_R; else if (wdog) fsm_d = S_FAULT;
      S_R: begin
        if (done) begin
          fsm_d = bus.enable ? S_G : S_IDLE;
          cyc_d = cyc_q + 8'd1;
        end else if (wdog) begin
          fsm_d = S_FAULT;
        end
      end
      S_FAULT: fsm_d = S_FAULT;
      default: fsm_d = S_FAULT;
    endcase

    trans     = (fsm_d != fsm_q);
    state_d   = trans ? phase_bits(fsm_d) : state_q;
    cnt_rst_d = trans;
    fault_d   = fault_q || (fsm_d == S_FAULT);

    if (trans || !in_phase) tmr_d = '0;
    else if (tmr_q != '1)   tmr_d = tmr_q + TMR_W'(1);
    else                    tmr_d = tmr_q;

    if (trans)             blk_d = BLK_W'(BLANK);
    else if (!blank_clr)   blk_d = blk_q - BLK_W'(1);
    else                   blk_d = blk_q;

    // Served on R entry, but a same-cycle request re-arms it.
    if (fsm_q == S_FAULT) ped_pend_d = ped_pend_q;
    else ped_pend_d = bus.ped_req || (ped_pend_q && !(trans && (fsm_d == S_R)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q      <= S_IDLE;
      state_q    <= '0;
      cnt_rst_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      fault_q    <= 1'b0;
      cyc_q      <= '0;
      tmr_q      <= '0;
      blk_q      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      cnt_rst_q  <= cnt_rst_d;
      ped_pend_q <= ped_pend_d;
      fault_q    <= fault_d;
      cyc_q      <= cyc_d;
      tmr_q      <= tmr_d;
      blk_q      <= blk_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.cnt_rst   = cnt_rst_q;
  assign bus.ped_pend  = ped_pend_q;
  assign bus.cycle_cnt = cyc_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_tl_seq_ctrl.sv
// Purpose : randomized scoreboard bench for tl_seq_ctrl; a timeline model
//           predicts every phase change, a monitor checks each cnt_rst event.
// Latency : n/a.
// Backpressure : n/a.
module tb_tl_seq_ctrl;
  localparam int MIN_G   = 64;
  localparam int TIMEOUT = 2047;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  tl_seq_ctrl_if #(.STATE_W(4)) bus();

  tl_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [7:0] cc;
    logic       flt;
    logic       ped;
  } exp_t;

  exp_t exp_q[$];

  // Model state: values visible on the outputs during the current phase.
  int m_cc;
  bit m_ped;
  bit m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Phase code: 0 IDLE, 1 INIT, 2 G, 3 Y, 4 R, 5 FAULT
  function automatic logic [3:0] onehot(input int p);
    case (p)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4, 5: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Drives one phase from its first cycle (j=0) to its exit cycle and queues
  // the predicted outcome. flag_at: cycle of the phase-done flag (in IDLE,
  // the cycle enable rises); ped_at: cycle of a ped_req pulse or -1.
  task automatic do_phase(input int ph, input int flag_at, input int ped_at, input bit en_exit);
    int         ex;
    int         nxt;
    int         cut;
    bit         flt;
    bit         req_before;
    logic [3:0] cur;
    logic [3:0] flags;
    exp_t       e;
    flt = 1'b0;
    ex  = flag_at;
    if (ph == 2) begin
      cut = 1 << 30;
      if (m_ped) cut = MIN_G;
      else if (ped_at >= 0) cut = (ped_at + 1 > MIN_G) ? ped_at + 1 : MIN_G;
      if (cut < ex) ex = cut;
    end
    if (ph != 0 && ex > TIMEOUT) begin
      ex  = TIMEOUT;
      flt = 1'b1;
    end
    case (ph)
      0: nxt = 1;
      1: nxt = 2;
      2: nxt = 3;
      3: nxt = 4;
      default: nxt = en_exit ? 2 : 0;
    endcase
    if (flt) nxt = 5;
    cur = onehot(ph);
    for (int j = 0; j <= ex; j++) begin
      if (ph == 0) bus.enable = (j == ex);
      else bus.enable = (j == ex) ? en_exit : 1'($urandom);
      bus.ped_req = (j == ped_at);
      flags = 4'($urandom) & ~cur;                       // off-phase noise
      if (j < 2 && $urandom_range(0, 1) == 1) flags = flags | cur;  // stale flag in blank
      if (ph != 0 && j == flag_at) flags = flags | cur;
      bus.int_flags = flags;
      if (j == ex) begin
        req_before = (ped_at >= 0) && (ped_at < ex);
        m_ped   = (ped_at == ex) || ((m_ped || req_before) && (nxt != 4));
        if (ph == 4 && !flt) m_cc = (m_cc + 1) % 256;
        if (flt) m_fault = 1'b1;
        e.cyc = cyc + 1;
        e.st  = onehot(nxt);
        e.cc  = 8'(m_cc);
        e.flt = m_fault;
        e.ped = m_ped;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.ped_req   = 1'b0;
    bus.int_flags = '0;
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_cnt_rst", 32'(bus.cnt_rst), 0);
    chk("rst_ped_pend", 32'(bus.ped_pend), 0);
    chk("rst_cycle_cnt", 32'(bus.cycle_cnt), 0);
    chk("rst_fault", 32'(bus.fault), 0);
    chk("rst_queue_empty", 32'(exp_q.size()), 0);
    m_cc    = 0;
    m_ped   = 1'b0;
    m_fault = 1'b0;
    reset   = 1'b0;
  endtask

  // Monitor: every cnt_rst pulse is a phase-change event and must match the
  // oldest prediction; a state change without cnt_rst is an error.
  initial begin : monitor
    logic [3:0] prev;
    logic       rst_s;
    exp_t       e;
    prev = '0;
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (rst_s) begin
        prev = bus.state;
      end else begin
        if (bus.cnt_rst === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: state=%b at cycle %0d, none predicted", bus.state, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("evt_cycle", 32'(cyc), 32'(e.cyc));
            chk("evt_state", 32'(bus.state), 32'(e.st));
            chk("evt_cycle_cnt", 32'(bus.cycle_cnt), 32'(e.cc));
            chk("evt_fault", 32'(bus.fault), 32'(e.flt));
            chk("evt_ped_pend", 32'(bus.ped_pend), 32'(e.ped));
          end
        end else if (bus.state !== prev) begin
          checks++;
          errors++;
          $display("FAIL state_change_no_cnt_rst: got %b from %b at cycle %0d", bus.state, prev, cyc);
        end
        prev = bus.state;
      end
    end
  end

  initial begin : stim
    int fa;
    int pa;
    checks = 0;
    errors = 0;
    reset_dut();
    repeat (5) @(negedge clk);  // IDLE with enable low: no event expected
    chk("idle_hold_state", 32'(bus.state), 0);

    // Nominal datapath timing
    do_phase(0, 3, -1, 1'b1);
    do_phase(1, 1024, -1, 1'b1);
    do_phase(2, 512, -1, 1'b1);
    do_phase(3, 512, -1, 1'b1);
    do_phase(4, 1024, -1, 1'b1);

    // Pedestrian cut-off at MIN_G, clear at R entry, same-cycle re-arm
    do_phase(2, 500, 10, 1'b1);
    do_phase(3, 20, -1, 1'b1);
    do_phase(4, 30, -1, 1'b1);
    do_phase(2, 100, -1, 1'b1);
    do_phase(3, 20, 20, 1'b1);
    do_phase(4, 30, -1, 1'b1);
    do_phase(2, 500, -1, 1'b1);
    do_phase(3, 2, -1, 1'b1);   // flag right as blank expires

    // Enable dropped: R exit to IDLE, request raised in IDLE is retained
    do_phase(4, 10, -1, 1'b0);
    do_phase(0, 6, 2, 1'b1);
    do_phase(1, 5, -1, 1'b1);
    do_phase(2, 300, -1, 1'b1);
    do_phase(3, 4, -1, 1'b1);
    do_phase(4, 4, -1, 1'b1);

    // Randomized cycles, long enough to wrap cycle_cnt
    for (int k = 0; k < 262; k++) begin
      fa = $urandom_range(2, 40);
      pa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 45)) : -1;
      do_phase(2, fa, pa, 1'b1);
      pa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : -1;
      do_phase(3, $urandom_range(2, 12), pa, 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        do_phase(4, $urandom_range(2, 12), -1, 1'b0);
        do_phase(0, $urandom_range(0, 4), -1, 1'b1);
        do_phase(1, $urandom_range(2, 8), -1, 1'b1);
      end else begin
        do_phase(4, $urandom_range(2, 12), -1, 1'b1);
      end
    end

    // Watchdog: Y flag withheld, FAULT is absorbing
    do_phase(2, 10, -1, 1'b1);
    do_phase(3, 5000, -1, 1'b1);
    for (int k = 0; k < 200; k++) begin
      bus.enable    = 1'($urandom);
      bus.ped_req   = 1'($urandom);
      bus.int_flags = 4'($urandom);
      @(negedge clk);
    end
    chk("fault_state", 32'(bus.state), 32'h8);
    chk("fault_sticky", 32'(bus.fault), 1);
    chk("fault_ped_hold", 32'(bus.ped_pend), 32'(m_ped));
    chk("fault_cnt_rst", 32'(bus.cnt_rst), 0);
    reset_dut();

    // Reset in the middle of R
    do_phase(0, 1, -1, 1'b1);
    do_phase(1, 4, -1, 1'b1);
    do_phase(2, 4, 1, 1'b1);
    do_phase(3, 4, -1, 1'b1);
    bus.int_flags = '0;
    bus.ped_req   = 1'b1;
    repeat (7) @(negedge clk);
    reset_dut();

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
